// File: rtl/rob_nway_pkg.sv
// Shared reorder-buffer definitions: default sizing and the per-entry record.
package rob_nway_pkg;

    localparam int NUM_ROB_DEFAULT   = 32;
    localparam int NUM_SUPER_DEFAULT = 2;
    localparam int ENTRY_PR_W        = 6;
    localparam int ENTRY_AR_W        = 5;

    typedef struct packed {
        logic                  valid;
        logic                  complete;
        logic                  halt;
        logic                  illegal;
        logic                  wr_mem;
        logic                  rd_mem;
        logic [ENTRY_PR_W-1:0] T_idx;
        logic [ENTRY_PR_W-1:0] Told_idx;
        logic [ENTRY_AR_W-1:0] dest_idx;
    } ROB_NWAY_ENTRY_t;

endpackage

// File: rtl/rob_nway_retire_sel.sv
// In-order retire chain: slot k retires only if every older slot retires and none of them halts.
module rob_nway_retire_sel #(
    parameter int NUM_SUPER = 2,
    parameter int CNT_W     = $clog2(NUM_SUPER + 1)
) (
    input  logic [NUM_SUPER-1:0] ready,
    input  logic [NUM_SUPER-1:0] stop,
    input  logic [NUM_SUPER-1:0] allow,
    input  logic                 halted,
    output logic [NUM_SUPER-1:0] retire_en,
    output logic [CNT_W-1:0]     retire_cnt
);

    always_comb begin
        logic go;
        go         = !halted;
        retire_en  = '0;
        retire_cnt = '0;
        for (int k = 0; k < NUM_SUPER; k++) begin
            go           = go & ready[k] & allow[k];
            retire_en[k] = go;
            retire_cnt   = retire_cnt + CNT_W'(go);
            go           = go & !stop[k];
        end
    end

endmodule

// File: rtl/rob_nway.sv
// N-wide reorder buffer: in-order dispatch and retire, CDB completion, single-cycle rollback.
module rob_nway
    import rob_nway_pkg::*;
#(
    parameter int NUM_ROB   = NUM_ROB_DEFAULT,
    parameter int NUM_SUPER = NUM_SUPER_DEFAULT,
    parameter int PR_W      = ENTRY_PR_W,
    parameter int AR_W      = ENTRY_AR_W,
    parameter int IDX_W     = $clog2(NUM_ROB)
) (
    input  logic                            clock,
    input  logic                            reset,
    input  logic                            en,
    input  logic [NUM_SUPER-1:0]            dispatch_valid,
    input  logic [NUM_SUPER-1:0][PR_W-1:0]  dispatch_T_idx,
    input  logic [NUM_SUPER-1:0][PR_W-1:0]  dispatch_Told_idx,
    input  logic [NUM_SUPER-1:0][AR_W-1:0]  dispatch_dest_idx,
    input  logic [NUM_SUPER-1:0]            dispatch_halt,
    input  logic [NUM_SUPER-1:0]            dispatch_illegal,
    input  logic [NUM_SUPER-1:0]            dispatch_wr_mem,
    input  logic [NUM_SUPER-1:0]            dispatch_rd_mem,
    output logic                            dispatch_ready,
    output logic [NUM_SUPER-1:0][IDX_W-1:0] dispatch_ROB_idx,
    input  logic [NUM_SUPER-1:0]            complete_en,
    input  logic [NUM_SUPER-1:0][IDX_W-1:0] complete_idx,
    input  logic                            rollback_en,
    input  logic [IDX_W-1:0]                rollback_idx,
    input  logic [NUM_SUPER-1:0]            retire_allow,
    output logic [NUM_SUPER-1:0]            retire_en,
    output logic [NUM_SUPER-1:0][PR_W-1:0]  retire_T_idx,
    output logic [NUM_SUPER-1:0][PR_W-1:0]  retire_Told_idx,
    output logic [NUM_SUPER-1:0][AR_W-1:0]  retire_dest_idx,
    output logic [NUM_SUPER-1:0]            retire_wr_mem,
    output logic [NUM_SUPER-1:0]            retire_rd_mem,
    output logic                            halt_out,
    output logic                            illegal_out,
    output logic [IDX_W:0]                  count,
    output logic                            empty,
    output logic                            full
);

    localparam int CNT_W = $clog2(NUM_SUPER + 1);

    // Entry fields are sized by the package; PR_W/AR_W must match it.
    ROB_NWAY_ENTRY_t rob [NUM_ROB];

    logic [IDX_W:0]                  head, tail, rb_tail;
    logic [IDX_W-1:0]                rb_off;
    logic [NUM_ROB-1:0]              rb_kill;
    logic                            rb_act, halted;
    logic [NUM_SUPER-1:0][IDX_W-1:0] hslot;
    logic [NUM_SUPER-1:0]            head_rdy, head_halt, head_ill;
    logic [CNT_W-1:0]                disp_cnt, retire_cnt;

    assign count          = tail - head;
    assign empty          = (count == '0);
    assign full           = (count == (IDX_W+1)'(NUM_ROB));
    assign dispatch_ready = (count <= (IDX_W+1)'(NUM_ROB - NUM_SUPER)) && !rollback_en && !halted;

    always_comb begin
        disp_cnt = '0;
        for (int k = 0; k < NUM_SUPER; k++) begin
            dispatch_ROB_idx[k] = tail[IDX_W-1:0] + IDX_W'(k);
            disp_cnt            = disp_cnt + CNT_W'(dispatch_valid[k]);
        end
    end

    always_comb begin
        for (int k = 0; k < NUM_SUPER; k++) begin
            hslot[k]           = head[IDX_W-1:0] + IDX_W'(k);
            head_rdy[k]        = rob[hslot[k]].valid & rob[hslot[k]].complete;
            head_halt[k]       = rob[hslot[k]].halt;
            head_ill[k]        = rob[hslot[k]].illegal;
            retire_T_idx[k]    = rob[hslot[k]].T_idx;
            retire_Told_idx[k] = rob[hslot[k]].Told_idx;
            retire_dest_idx[k] = rob[hslot[k]].dest_idx;
            retire_wr_mem[k]   = rob[hslot[k]].wr_mem;
            retire_rd_mem[k]   = rob[hslot[k]].rd_mem;
        end
    end

    rob_nway_retire_sel #(
        .NUM_SUPER (NUM_SUPER),
        .CNT_W     (CNT_W)
    ) u_retire_sel (
        .ready      (head_rdy),
        .stop       (head_halt | head_ill),
        .allow      (retire_allow),
        .halted     (halted),
        .retire_en  (retire_en),
        .retire_cnt (retire_cnt)
    );

    assign halt_out    = |(retire_en & head_halt);
    assign illegal_out = |(retire_en & head_ill);

    // Branch offset from head picks the wrap bit of the new tail, keeping count <= NUM_ROB.
    assign rb_act  = rollback_en && rob[rollback_idx].valid;
    assign rb_off  = rollback_idx - head[IDX_W-1:0];
    assign rb_tail = head + {1'b0, rb_off} + (IDX_W+1)'(1);

    always_comb begin
        for (int i = 0; i < NUM_ROB; i++)
            rb_kill[i] = (IDX_W'(i) - head[IDX_W-1:0]) > rb_off;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            head   <= '0;
            tail   <= '0;
            halted <= 1'b0;
            for (int i = 0; i < NUM_ROB; i++)
                rob[i] <= '0;
        end else if (en) begin
            // Later writes win: completion, then squash, then retire clear, then dispatch.
            for (int i = 0; i < NUM_ROB; i++) begin
                for (int k = 0; k < NUM_SUPER; k++)
                    if (complete_en[k] && complete_idx[k] == IDX_W'(i) && rob[i].valid)
                        rob[i].complete <= 1'b1;
                if (rb_act && rb_kill[i]) begin
                    rob[i].valid    <= 1'b0;
                    rob[i].complete <= 1'b0;
                end
            end
            for (int k = 0; k < NUM_SUPER; k++)
                if (retire_en[k]) begin
                    rob[hslot[k]].valid    <= 1'b0;
                    rob[hslot[k]].complete <= 1'b0;
                end
            for (int k = 0; k < NUM_SUPER; k++)
                if (dispatch_ready && dispatch_valid[k])
                    rob[dispatch_ROB_idx[k]] <= '{
                        valid:    1'b1,
                        complete: dispatch_halt[k] | dispatch_illegal[k],
                        halt:     dispatch_halt[k],
                        illegal:  dispatch_illegal[k],
                        wr_mem:   dispatch_wr_mem[k],
                        rd_mem:   dispatch_rd_mem[k],
                        T_idx:    dispatch_T_idx[k],
                        Told_idx: dispatch_Told_idx[k],
                        dest_idx: dispatch_dest_idx[k]
                    };
            head <= head + (IDX_W+1)'(retire_cnt);
            if (rb_act)
                tail <= rb_tail;
            else if (dispatch_ready)
                tail <= tail + (IDX_W+1)'(disp_cnt);
            halted <= halted | halt_out | illegal_out;
        end
    end

    dispatch_contiguous: assert property (@(posedge clock) disable iff (reset)
        (en && dispatch_ready) |-> ((dispatch_valid & (dispatch_valid + NUM_SUPER'(1))) == '0));

endmodule

// File: tb/tb_rob_nway.sv
// Randomised scoreboard bench for rob_nway against a queue-based program-order model.
module tb_rob_nway;

    localparam int NR    = 32;
    localparam int NS    = 2;
    localparam int PR_W  = 6;
    localparam int AR_W  = 5;
    localparam int IDX_W = 5;

    logic clock = 1'b0;
    logic reset = 1'b1;
    logic en;
    logic [NS-1:0]            dispatch_valid, dispatch_halt, dispatch_illegal, dispatch_wr_mem, dispatch_rd_mem;
    logic [NS-1:0][PR_W-1:0]  dispatch_T_idx, dispatch_Told_idx;
    logic [NS-1:0][AR_W-1:0]  dispatch_dest_idx;
    logic                     dispatch_ready;
    logic [NS-1:0][IDX_W-1:0] dispatch_ROB_idx;
    logic [NS-1:0]            complete_en;
    logic [NS-1:0][IDX_W-1:0] complete_idx;
    logic                     rollback_en;
    logic [IDX_W-1:0]         rollback_idx;
    logic [NS-1:0]            retire_allow, retire_en, retire_wr_mem, retire_rd_mem;
    logic [NS-1:0][PR_W-1:0]  retire_T_idx, retire_Told_idx;
    logic [NS-1:0][AR_W-1:0]  retire_dest_idx;
    logic                     halt_out, illegal_out, empty, full;
    logic [IDX_W:0]           count;

    rob_nway dut (
        .clock(clock), .reset(reset), .en(en),
        .dispatch_valid(dispatch_valid), .dispatch_T_idx(dispatch_T_idx),
        .dispatch_Told_idx(dispatch_Told_idx), .dispatch_dest_idx(dispatch_dest_idx),
        .dispatch_halt(dispatch_halt), .dispatch_illegal(dispatch_illegal),
        .dispatch_wr_mem(dispatch_wr_mem), .dispatch_rd_mem(dispatch_rd_mem),
        .dispatch_ready(dispatch_ready), .dispatch_ROB_idx(dispatch_ROB_idx),
        .complete_en(complete_en), .complete_idx(complete_idx),
        .rollback_en(rollback_en), .rollback_idx(rollback_idx),
        .retire_allow(retire_allow), .retire_en(retire_en),
        .retire_T_idx(retire_T_idx), .retire_Told_idx(retire_Told_idx),
        .retire_dest_idx(retire_dest_idx), .retire_wr_mem(retire_wr_mem),
        .retire_rd_mem(retire_rd_mem), .halt_out(halt_out), .illegal_out(illegal_out),
        .count(count), .empty(empty), .full(full)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [PR_W-1:0] t, told;
        logic [AR_W-1:0] dest;
        bit halt, ill, wr, rd, cmp;
    } ment_t;
    typedef struct {
        logic [PR_W-1:0] t, told;
        logic [AR_W-1:0] dest;
        bit wr, rd;
    } ret_t;
    typedef struct {
        bit rdy, emp, ful, h, il;
        int cnt;
        logic [NS-1:0] ren;
        logic [IDX_W-1:0] d0, d1;
    } stat_t;

    ment_t mq[$];       // occupied entries, oldest first
    ret_t  rq[$];
    stat_t sq[$];
    int    hd = 0;      // ROB index of the oldest entry
    bit    halted = 0;

    int vectors = 0, miscompares = 0;

    task automatic chk(string nm, longint act, longint exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clock) begin : monitor
        stat_t s;
        ret_t  r;
        if (sq.size() > 0) begin
            s = sq.pop_front();
            chk("dispatch_ready", dispatch_ready, s.rdy);
            chk("count", count, s.cnt);
            chk("empty", empty, s.emp);
            chk("full", full, s.ful);
            chk("retire_en", retire_en, s.ren);
            chk("halt_out", halt_out, s.h);
            chk("illegal_out", illegal_out, s.il);
            chk("dispatch_ROB_idx", dispatch_ROB_idx, {s.d1, s.d0});
            if (en)
                for (int k = 0; k < NS; k++)
                    if (retire_en[k]) begin
                        if (rq.size() == 0) begin
                            vectors++;
                            miscompares++;
                            $display("FAIL retire_unexpected: slot %0d retired, none expected", k);
                        end else begin
                            r = rq.pop_front();
                            chk("retire_data",
                                {retire_T_idx[k], retire_Told_idx[k], retire_dest_idx[k], retire_wr_mem[k], retire_rd_mem[k]},
                                {r.t, r.told, r.dest, r.wr, r.rd});
                        end
                    end
        end
    end

    task automatic quiet();
        en = 1'b1;
        dispatch_valid = '0; dispatch_halt = '0; dispatch_illegal = '0;
        dispatch_wr_mem = '0; dispatch_rd_mem = '0;
        dispatch_T_idx = '0; dispatch_Told_idx = '0; dispatch_dest_idx = '0;
        complete_en = '0; complete_idx = '0;
        rollback_en = 1'b0; rollback_idx = '0;
        retire_allow = '1;
    endtask

    task automatic rand_fields();
        for (int k = 0; k < NS; k++) begin
            dispatch_T_idx[k]    = PR_W'($urandom);
            dispatch_Told_idx[k] = PR_W'($urandom);
            dispatch_dest_idx[k] = AR_W'($urandom);
            dispatch_wr_mem[k]   = 1'($urandom);
            dispatch_rd_mem[k]   = 1'($urandom);
        end
    endtask

    // Record expected outputs for the current inputs, advance the model, then wait one clock.
    task automatic step();
        stat_t s;
        ment_t e;
        int n, p;
        bit go;
        s.cnt = mq.size();
        s.emp = (s.cnt == 0);
        s.ful = (s.cnt == NR);
        s.rdy = (NR - s.cnt >= NS) && !rollback_en && !halted;
        s.d0  = IDX_W'((hd + s.cnt) % NR);
        s.d1  = IDX_W'((hd + s.cnt + 1) % NR);
        s.ren = '0; s.h = 0; s.il = 0;
        n = 0;
        go = !halted;
        for (int k = 0; k < NS; k++) begin
            if (go && k < mq.size() && mq[k].cmp && retire_allow[k]) begin
                s.ren[k] = 1'b1;
                n++;
                s.h  |= mq[k].halt;
                s.il |= mq[k].ill;
                if (en) rq.push_back('{mq[k].t, mq[k].told, mq[k].dest, mq[k].wr, mq[k].rd});
                go = !(mq[k].halt || mq[k].ill);
            end else
                go = 0;
        end
        sq.push_back(s);
        if (en) begin
            for (int k = 0; k < NS; k++)
                if (complete_en[k]) begin
                    p = (int'(complete_idx[k]) - hd + NR) % NR;
                    if (p < mq.size()) mq[p].cmp = 1;
                end
            if (rollback_en) begin
                p = (int'(rollback_idx) - hd + NR) % NR;
                if (p < mq.size())
                    while (mq.size() > p + 1) void'(mq.pop_back());
            end
            repeat (n) void'(mq.pop_front());
            hd = (hd + n) % NR;
            if (s.h || s.il) halted = 1;
            if (s.rdy)
                for (int k = 0; k < NS; k++)
                    if (dispatch_valid[k]) begin
                        e.t = dispatch_T_idx[k]; e.told = dispatch_Told_idx[k];
                        e.dest = dispatch_dest_idx[k];
                        e.halt = dispatch_halt[k]; e.ill = dispatch_illegal[k];
                        e.wr = dispatch_wr_mem[k]; e.rd = dispatch_rd_mem[k];
                        e.cmp = dispatch_halt[k] | dispatch_illegal[k];
                        mq.push_back(e);
                    end
        end
        @(posedge clock);
        #1;
    endtask

    task automatic rand_cycle(int cpct);
        int n, p, sz;
        sz = mq.size();
        quiet();
        rand_fields();
        en = ($urandom_range(0, 15) != 0);
        n = $urandom_range(0, NS);
        dispatch_valid = NS'((1 << n) - 1);
        for (int k = 0; k < NS; k++) begin
            complete_idx[k] = IDX_W'($urandom);
            if ($urandom_range(0, 99) < cpct) begin
                complete_en[k] = 1'b1;
                if (sz > 0 && $urandom_range(0, 7) != 0)
                    complete_idx[k] = IDX_W'((hd + $urandom_range(0, sz - 1)) % NR);
            end
        end
        retire_allow = ($urandom_range(0, 3) == 0) ? NS'($urandom) : '1;
        rollback_idx = IDX_W'($urandom);
        if ($urandom_range(0, 19) == 0) begin
            p = (sz > 0) ? $urandom_range(0, sz - 1) : 0;
            // A mispredicted branch is still incomplete, so nothing younger can retire alongside it.
            if (sz > 0 && !mq[p].cmp) begin
                rollback_en  = 1'b1;
                rollback_idx = IDX_W'((hd + p) % NR);
            end else if (sz < NR) begin
                rollback_en  = 1'b1;
                rollback_idx = IDX_W'((hd + $urandom_range(sz, NR - 1)) % NR);
            end
        end
    endtask

    task automatic do_reset();
        quiet();
        reset = 1'b1;
        @(posedge clock);
        #1;
        reset = 1'b0;
        mq.delete();
        hd = 0;
        halted = 0;
    endtask

    task automatic fill();
        for (int c = 0; c < NR / NS; c++) begin
            quiet(); rand_fields(); dispatch_valid = '1; step();
        end
    endtask

    initial begin
        int m;
        quiet();
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0;

        // Fill to full, then complete out of order.
        fill();
        quiet(); dispatch_valid = '1; complete_en = 2'b01; complete_idx[0] = 5'd1; step();
        quiet(); complete_en = 2'b01; complete_idx[0] = 5'd0; step();
        quiet(); step();

        // Drain to head=30, dispatch across the wrap, roll back to entry 31.
        for (int c = 0; c < 64 && hd != 30; c++) begin
            quiet();
            m = 0;
            for (int p = 0; p < mq.size() && m < NS; p++)
                if (!mq[p].cmp && (hd + p) % NR < 30) begin
                    complete_en[m]  = 1'b1;
                    complete_idx[m] = IDX_W'((hd + p) % NR);
                    m++;
                end
            step();
        end
        quiet(); rand_fields(); dispatch_valid = '1; step();
        quiet(); dispatch_valid = '1; rollback_en = 1'b1; rollback_idx = 5'd31; step();
        quiet(); step();

        for (int c = 0; c < 1500; c++) begin
            rand_cycle(c < 500 ? 20 : 45);
            step();
        end

        // Asynchronous reset while full and a rollback is being presented.
        do_reset();
        fill();
        quiet(); rollback_en = 1'b1; rollback_idx = 5'd7;
        chk("pre_reset_full", full, mq.size() == NR);
        #2;
        reset = 1'b1;
        rollback_en = 1'b0;
        #1;
        chk("async_count", count, 0);
        chk("async_empty", empty, 1);
        chk("async_full", full, 0);
        chk("async_ready", dispatch_ready, 1);
        chk("async_retire_en", retire_en, 0);
        chk("async_halt", halt_out, 0);
        chk("async_illegal", illegal_out, 0);
        @(posedge clock);
        #1;
        reset = 1'b0;
        mq.delete();
        hd = 0;
        halted = 0;

        // Halt, then illegal, each retiring with a complete younger sibling that must wait forever.
        for (int f = 0; f < 2; f++) begin
            do_reset();
            quiet(); rand_fields(); dispatch_valid = '1;
            if (f == 0) dispatch_halt[0] = 1'b1; else dispatch_illegal[0] = 1'b1;
            step();
            quiet(); complete_en = 2'b01; complete_idx[0] = 5'd1; step();
            quiet(); rand_fields(); dispatch_valid = '1; step();
            for (int c = 0; c < 4; c++) begin
                quiet(); dispatch_valid = '1; complete_en = '1;
                complete_idx[0] = 5'd2; complete_idx[1] = 5'd3;
                step();
            end
        end

        quiet();
        repeat (2) @(posedge clock);
        chk("sb_status_drained", sq.size(), 0);
        chk("sb_retire_drained", rq.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: bench did not finish within 1000000 ns");
        $fatal(1, "timeout");
    end

endmodule
